// File: rtl/video_mode_switcher.sv
// video_mode_switcher
//   Debounces a raw mode code, decodes it against a parametrised code table and
//   applies the resulting mode only at a frame boundary. Every switch is
//   bracketed by a pipeline hold window so downstream timing never sees a torn
//   frame.
//
// Ports:
//   clock          in   video-domain clock
//   reset_n        in   asynchronous active-low reset
//   data_in        in   raw mode code
//   frame_end      in   one-cycle pulse at the end of the last active line
//   videoMode      out  timing record of the current mode
//                       {h_active, v_active, h_total, v_total}, 12 bits each
//   mode_index     out  current mode index
//   switch_pending out  an accepted switch is waiting for a frame boundary
//   pipeline_hold  out  timing generator must freeze and blank output
//   mode_changed   out  one-cycle pulse on the cycle videoMode updates
//   invalid_code   out  the stable code matches no table entry

module video_mode_switcher #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned NUM_MODES     = 3,
    // Entry i at [i*DATA_WIDTH +: DATA_WIDTH]: 0 = 1080p (8'h10), 1 = 720p (8'h04),
    // 2 = VGA (8'h01)
    parameter logic [NUM_MODES*DATA_WIDTH-1:0] MODE_CODES = {8'h01, 8'h04, 8'h10},
    // Timing record of entry i at [i*48 +: 48]
    parameter logic [NUM_MODES*48-1:0] MODE_TIMINGS = {
        12'd640,  12'd480,  12'd800,  12'd525,
        12'd1280, 12'd720,  12'd1650, 12'd750,
        12'd1920, 12'd1080, 12'd2200, 12'd1125
    },
    parameter int unsigned DEFAULT_MODE  = 0,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 2,
    parameter int unsigned FRAME_TIMEOUT = 2**20
) (
    input  logic                                                 clock,
    input  logic                                                 reset_n,
    input  logic [DATA_WIDTH-1:0]                                data_in,
    input  logic                                                 frame_end,
    output logic [47:0]                                          videoMode,
    output logic [((NUM_MODES > 1) ? $clog2(NUM_MODES) : 1)-1:0] mode_index,
    output logic                                                 switch_pending,
    output logic                                                 pipeline_hold,
    output logic                                                 mode_changed,
    output logic                                                 invalid_code
);

    localparam int unsigned IDX_W  = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned TO_W   = $clog2(FRAME_TIMEOUT + 1);
    localparam int unsigned VM_W   = 48;

    localparam logic [IDX_W-1:0] DEFAULT_IDX  = IDX_W'(DEFAULT_MODE);
    localparam logic [VM_W-1:0]  DEFAULT_VM   = MODE_TIMINGS[DEFAULT_MODE*VM_W +: VM_W];
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TO_W-1:0]  TIMEOUT_LAST = TO_W'(FRAME_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StRun,
        StWaitFrame,
        StHoldPre,
        StApply,
        StHoldPost
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_in_reg_q, data_in_reg_d;
    logic [CNT_W-1:0]      stable_cnt_q, stable_cnt_d;
    logic [IDX_W-1:0]      pend_idx_q, pend_idx_d;
    logic [IDX_W-1:0]      mode_index_q, mode_index_d;
    logic [VM_W-1:0]       video_mode_q, video_mode_d;
    logic [TO_W-1:0]       timeout_cnt_q, timeout_cnt_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic                  switch_pending_q, switch_pending_d;
    logic                  pipeline_hold_q, pipeline_hold_d;
    logic                  mode_changed_q, mode_changed_d;
    logic                  invalid_code_q, invalid_code_d;

    logic                  stable;
    logic                  match;
    logic [IDX_W-1:0]      cand;

    function automatic logic [VM_W-1:0] timing_of(input logic [IDX_W-1:0] idx);
        return MODE_TIMINGS[int'(idx)*VM_W +: VM_W];
    endfunction

    assign stable = (stable_cnt_q == CNT_W'(STABLE_CYCLES));

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        match = 1'b0;
        cand  = '0;
        for (int i = NUM_MODES - 1; i >= 0; i--) begin
            if (data_in_reg_q == MODE_CODES[i*DATA_WIDTH +: DATA_WIDTH]) begin
                match = 1'b1;
                cand  = IDX_W'(i);
            end
        end
    end

    always_comb begin
        data_in_reg_d    = data_in;
        stable_cnt_d     = stable_cnt_q;
        state_d          = state_q;
        pend_idx_d       = pend_idx_q;
        mode_index_d     = mode_index_q;
        video_mode_d     = video_mode_q;
        timeout_cnt_d    = timeout_cnt_q;
        hold_cnt_d       = hold_cnt_q;
        switch_pending_d = switch_pending_q;
        pipeline_hold_d  = pipeline_hold_q;
        mode_changed_d   = 1'b0;
        invalid_code_d   = invalid_code_q;

        if (data_in != data_in_reg_q) begin
            stable_cnt_d = '0;
        end else if (!stable) begin
            stable_cnt_d = stable_cnt_q + CNT_W'(1);
        end

        if (stable) begin
            invalid_code_d = !match;
        end

        case (state_q)
            StRun: begin
                if (stable && match && (cand != mode_index_q)) begin
                    pend_idx_d       = cand;
                    switch_pending_d = 1'b1;
                    timeout_cnt_d    = '0;
                    state_d          = StWaitFrame;
                end
            end
            StWaitFrame: begin
                timeout_cnt_d = timeout_cnt_q + TO_W'(1);
                if (stable && match && (cand == mode_index_q)) begin
                    // Code reverted to the running mode: cancel, frame_end is moot.
                    switch_pending_d = 1'b0;
                    state_d          = StRun;
                end else begin
                    if (stable && match) begin
                        pend_idx_d = cand;
                    end
                    if (frame_end || (timeout_cnt_q == TIMEOUT_LAST)) begin
                        pipeline_hold_d = 1'b1;
                        hold_cnt_d      = '0;
                        state_d         = StHoldPre;
                    end
                end
            end
            StHoldPre: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    // Outputs are registered, so the update lands in the APPLY cycle.
                    mode_index_d     = pend_idx_q;
                    video_mode_d     = timing_of(pend_idx_q);
                    mode_changed_d   = 1'b1;
                    switch_pending_d = 1'b0;
                    state_d          = StApply;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            StApply: begin
                hold_cnt_d = '0;
                state_d    = StHoldPost;
            end
            StHoldPost: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    pipeline_hold_d = 1'b0;
                    state_d         = StRun;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= StRun;
            data_in_reg_q    <= '0;
            stable_cnt_q     <= '0;
            pend_idx_q       <= DEFAULT_IDX;
            mode_index_q     <= DEFAULT_IDX;
            video_mode_q     <= DEFAULT_VM;
            timeout_cnt_q    <= '0;
            hold_cnt_q       <= '0;
            switch_pending_q <= 1'b0;
            pipeline_hold_q  <= 1'b0;
            mode_changed_q   <= 1'b0;
            invalid_code_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            data_in_reg_q    <= data_in_reg_d;
            stable_cnt_q     <= stable_cnt_d;
            pend_idx_q       <= pend_idx_d;
            mode_index_q     <= mode_index_d;
            video_mode_q     <= video_mode_d;
            timeout_cnt_q    <= timeout_cnt_d;
            hold_cnt_q       <= hold_cnt_d;
            switch_pending_q <= switch_pending_d;
            pipeline_hold_q  <= pipeline_hold_d;
            mode_changed_q   <= mode_changed_d;
            invalid_code_q   <= invalid_code_d;
        end
    end

    assign videoMode      = video_mode_q;
    assign mode_index     = mode_index_q;
    assign switch_pending = switch_pending_q;
    assign pipeline_hold  = pipeline_hold_q;
    assign mode_changed   = mode_changed_q;
    assign invalid_code   = invalid_code_q;

endmodule

// File: tb/tb_video_mode_switcher.sv
// Testbench for video_mode_switcher: directed scenarios plus randomized code
// streams, checked cycle by cycle against a behavioural model through a queue.

module tb_video_mode_switcher;

    localparam int S  = 4;   // stable samples needed
    localparam int H  = 2;   // hold cycles either side of the update
    localparam int FT = 16;  // frame timeout used for this instance

    localparam logic [7:0] CODE_1080 = 8'h10;
    localparam logic [7:0] CODE_720  = 8'h04;
    localparam logic [7:0] CODE_VGA  = 8'h01;

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b0;
    logic [7:0]  data_in   = CODE_VGA;
    logic        frame_end = 1'b0;
    logic [47:0] videoMode;
    logic [1:0]  mode_index;
    logic        switch_pending;
    logic        pipeline_hold;
    logic        mode_changed;
    logic        invalid_code;

    video_mode_switcher #(
        .FRAME_TIMEOUT(FT)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .data_in       (data_in),
        .frame_end     (frame_end),
        .videoMode     (videoMode),
        .mode_index    (mode_index),
        .switch_pending(switch_pending),
        .pipeline_hold (pipeline_hold),
        .mode_changed  (mode_changed),
        .invalid_code  (invalid_code)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [47:0] vm;
        logic [1:0]  idx;
        logic        pend;
        logic        hold;
        logic        chg;
        logic        inv;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: phase 0 idle, 1 waiting for a frame, 2 inside the hold
    // window at position m_hpos (1 .. 2H+1, update lands at H+1).
    int         m_mode, m_pend, m_phase, m_wait, m_hpos, m_age;
    logic [7:0] m_last;
    bit         m_inv, m_chg;

    logic [7:0] cur_din = CODE_VGA;
    logic       cur_fe  = 1'b0;
    logic       cur_rst = 1'b0;

    function automatic logic [47:0] ref_timing(input int m);
        case (m)
            0:       return {12'd1920, 12'd1080, 12'd2200, 12'd1125};
            1:       return {12'd1280, 12'd720, 12'd1650, 12'd750};
            default: return {12'd640, 12'd480, 12'd800, 12'd525};
        endcase
    endfunction

    function automatic int ref_decode(input logic [7:0] c);
        if (c == CODE_1080) return 0;
        if (c == CODE_720) return 1;
        if (c == CODE_VGA) return 2;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pend = 0; m_phase = 0; m_wait = 0; m_hpos = 0;
        m_age = 0; m_last = 8'h00; m_inv = 0; m_chg = 0;
    endtask

    task automatic model_step(input logic [7:0] din, input logic fe);
        bit stable;
        int c;
        stable = (m_age == S);
        c      = ref_decode(m_last);
        if (din != m_last) m_age = 0;
        else if (m_age < S) m_age++;
        m_last = din;
        if (stable) m_inv = (c < 0);
        m_chg = 0;
        case (m_phase)
            0: if (stable && c >= 0 && c != m_mode) begin
                m_pend = c; m_phase = 1; m_wait = 0;
            end
            1: begin
                if (stable && c >= 0 && c == m_mode) begin
                    m_phase = 0;
                end else begin
                    if (stable && c >= 0) m_pend = c;
                    if (fe || m_wait == FT - 1) begin
                        m_phase = 2; m_hpos = 1;
                    end
                end
                m_wait++;
            end
            default: begin
                m_hpos++;
                if (m_hpos == H + 1) begin
                    m_mode = m_pend; m_chg = 1;
                end
                if (m_hpos == 2 * H + 2) m_phase = 0;
            end
        endcase
    endtask

    task automatic push_expected();
        exp_t e;
        e.vm   = ref_timing(m_mode);
        e.idx  = 2'(m_mode);
        e.pend = (m_phase == 1) || (m_phase == 2 && m_hpos <= H);
        e.hold = (m_phase == 2);
        e.chg  = m_chg;
        e.inv  = m_inv;
        exp_q.push_back(e);
    endtask

    // One clock: model the edge just passed, queue its expectation, then drive
    // the inputs for the next edge. Asserting reset takes effect at once.
    task automatic cycle(input logic [7:0] din, input logic fe, input logic rst);
        @(posedge clock);
        #1;
        if (!cur_rst || !rst) model_reset();
        else model_step(cur_din, cur_fe);
        push_expected();
        data_in   = din;
        frame_end = fe;
        reset_n   = rst;
        cur_din   = din;
        cur_fe    = fe;
        cur_rst   = rst;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    task automatic drive_until_pending(input logic [7:0] din, input int bound);
        int n;
        n = 0;
        while (m_phase != 1 && n < bound) begin
            cycle(din, 1'b0, 1'b1);
            n++;
        end
        checks++;
        if (m_phase != 1) begin
            errors++;
            $display("FAIL reach_pending: phase %0d after %0d cycles, expected 1", m_phase, bound);
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("videoMode", 64'(videoMode), 64'(e.vm));
            chk("mode_index", 64'(mode_index), 64'(e.idx));
            chk("switch_pending", 64'(switch_pending), 64'(e.pend));
            chk("pipeline_hold", 64'(pipeline_hold), 64'(e.hold));
            chk("mode_changed", 64'(mode_changed), 64'(e.chg));
            chk("invalid_code", 64'(invalid_code), 64'(e.inv));
        end
    end

    initial begin
        logic [7:0] code;
        int         len;
        int         n;
        model_reset();

        // Power-up with VGA requested while the default (1080p) is loaded.
        repeat (3) cycle(CODE_VGA, 1'b0, 1'b0);
        drive_until_pending(CODE_VGA, 20);
        repeat (4) cycle(CODE_VGA, 1'b0, 1'b1);
        cycle(CODE_VGA, 1'b1, 1'b1);
        repeat (10) cycle(CODE_VGA, 1'b0, 1'b1);

        // Bouncing code never settles long enough to be accepted.
        for (int i = 0; i < 40; i++) begin
            cycle(((i / 3) % 2 == 0) ? CODE_720 : CODE_1080, 1'b0, 1'b1);
        end

        // Full switch to 720p with frame_end about 10 cycles after acceptance.
        drive_until_pending(CODE_720, 20);
        repeat (9) cycle(CODE_720, 1'b0, 1'b1);
        cycle(CODE_720, 1'b1, 1'b1);
        repeat (10) cycle(CODE_720, 1'b0, 1'b1);

        // Retarget 1080p -> VGA while waiting, then frame_end.
        drive_until_pending(CODE_1080, 20);
        repeat (2) cycle(CODE_1080, 1'b0, 1'b1);
        repeat (7) cycle(CODE_VGA, 1'b0, 1'b1);
        cycle(CODE_VGA, 1'b1, 1'b1);
        repeat (12) cycle(CODE_VGA, 1'b0, 1'b1);

        // Cancel by reverting to the running mode's code.
        drive_until_pending(CODE_720, 20);
        repeat (2) cycle(CODE_720, 1'b0, 1'b1);
        repeat (20) cycle(CODE_VGA, 1'b0, 1'b1);

        // Unknown code held stable, then a switch forced by the frame timeout.
        repeat (20) cycle(8'hFF, 1'b0, 1'b1);
        drive_until_pending(CODE_1080, 20);
        repeat (30) cycle(CODE_1080, 1'b0, 1'b1);

        // Randomized code streams with sporadic frame_end pulses.
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 5))
                0:       code = CODE_1080;
                1:       code = CODE_720;
                2:       code = CODE_VGA;
                3:       code = 8'hFF;
                4:       code = 8'h00;
                default: code = 8'($urandom);
            endcase
            len = int'($urandom_range(1, 12));
            for (int j = 0; j < len; j++) begin
                cycle(code, ($urandom_range(0, 7) == 0), 1'b1);
            end
        end

        // Settle, then reset in the middle of the pre-update hold.
        repeat (25) cycle(8'hFF, 1'b1, 1'b1);
        code = (m_mode == 0) ? CODE_720 : CODE_1080;
        n = 0;
        while (!(m_phase == 2 && m_hpos == 1) && n < 60) begin
            cycle(code, (m_phase == 1 && m_wait >= 3), 1'b1);
            n++;
        end
        checks++;
        if (!(m_phase == 2 && m_hpos == 1)) begin
            errors++;
            $display("FAIL reach_hold: phase %0d hpos %0d, expected 2 and 1", m_phase, m_hpos);
        end
        repeat (3) cycle(code, 1'b0, 1'b0);
        repeat (20) cycle(code, 1'b0, 1'b1);

        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
